s_axi_write_mux: RTL
====================

# s_axi_write_mux

Parametrised AXI4-Lite write slave for the DFX sequencer register file, generalising the single-outstanding write port to N slot-table rows, F per-slot fields and R bank0 registers. AW and W are accepted independently in either order. Commits stall on a bank-side ready, and unmapped addresses return SLVERR. It sits between the PS AXI-Lite master and the bank0 control/status registers and the bank1 slot table, and provides write/error counters for profiling.

## Interface
- ADDR_WIDTH, 16, AXI address width (≥ 8 + BANK1_INDEX_WIDTH)
- DATA_WIDTH, 32, AXI data width (32 or 64)
- BANK1_INDEX_WIDTH, 2, slot-index bits; slot count = 2^BANK1_INDEX_WIDTH
- BANK1_FIELD_COUNT, 6, mapped fields per slot (≤ 16)
- BANK0_REG_COUNT, 4, mapped bank0 registers (≤ 2^(ADDR_WIDTH-8))
- CNT_WIDTH, 16, width of the saturating write/error counters
- clk in 1, sole clock
- reset in 1, synchronous active-high
- S_AXI_AWADDR in ADDR_WIDTH; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1
- S_AXI_WDATA in DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1
- ext_wr_ready in 1, banks can accept a commit this cycle
- ext_wr_index out BANK1_INDEX_WIDTH, latched slot index
- ext_wr_data out DATA_WIDTH, latched WDATA
- ext_wr_strb out DATA_WIDTH/8, latched WSTRB
- ext_bank1_set out BANK1_FIELD_COUNT, one-hot field write pulse
- ext_bank0_set out BANK0_REG_COUNT, one-hot register write pulse
- wr_ok_cnt out CNT_WIDTH, count of committed OKAY writes
- wr_err_cnt out CNT_WIDTH, count of SLVERR writes

## Operation
- Address decode on latched AWADDR: bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the bank (00 = bank0, 01 = bank1, other values unmapped).
  - bank0: register number = addr[ADDR_WIDTH-3:6]; mapped when < BANK0_REG_COUNT and addr[5:0] == 0.
  - bank1: slot = addr[6+BANK1_INDEX_WIDTH-1:6], field = addr[5:2]; mapped when field < BANK1_FIELD_COUNT, addr[ADDR_WIDTH-3:6+BANK1_INDEX_WIDTH] == 0 and addr[1:0] == 0.
- State machine:
  - IDLE: collects AW and W into aw_held/w_held flags and registers. AWREADY = !aw_held; WREADY = !w_held. When both are held (including same-cycle acceptance), go to COMMIT.
  - COMMIT: if the address is unmapped, latch SLVERR (2'b10), increment wr_err_cnt and go to RESP without any set pulse. If mapped and ext_wr_ready = 1, assert exactly one bit of ext_bank0_set/ext_bank1_set for one cycle, provided WSTRB ≠ 0; latch OKAY, increment wr_ok_cnt and go to RESP. If mapped and ext_wr_ready = 0, stay in COMMIT.
  - RESP: BVALID = 1 with the latched BRESP. On BREADY, clear the held flags and go to IDLE.
- Writes with WSTRB = 0 to a mapped address: no set pulse, OKAY response, wr_ok_cnt increments.
- Set pulses are combinational from state, ext_wr_ready and the registered decode. ext_wr_index, ext_wr_data and ext_wr_strb are registered and stay stable from COMMIT through RESP.
- Counters saturate at 2^CNT_WIDTH-1.
- Reset values: all outputs 0; BRESP 2'b00; state IDLE; held flags cleared. Reset at any point abandons an in-flight transaction with no set pulse and no response.

## Timing
- AW and W accepted on cycle N (the later of the two) → COMMIT on N+1 → set pulse on N+1 when ext_wr_ready is high → BVALID on N+2.
- Each cycle ext_wr_ready is low in COMMIT adds one cycle to this latency.
- Single outstanding write: AWREADY and WREADY stay low from the second acceptance until the cycle after the B handshake.
- Back-to-back throughput: one write per 3 cycles, with BREADY held high.
- AWREADY and WREADY do not depend combinationally on AWVALID or WVALID.

## Test plan
- AW then W two cycles later to bank1 slot 2 field 1 (addr 0x4084), data 0x1234, strb 0xF, ext_wr_ready = 1 → ext_bank1_set = 6'b000010 for one cycle, ext_wr_index = 2, BRESP OKAY, wr_ok_cnt = 1.
- W before AW, then same-cycle AW+W, to bank0 reg 3 (addr 0x00C0) → ext_bank0_set = 4'b1000 pulse both times, latency exactly N+1 / N+2.
- Writes to 0x8000, 0x4098 (field 6) and 0x0102 → no set pulse, BRESP 2'b10, wr_err_cnt = 3.
- ext_wr_ready low for 5 cycles in COMMIT → set pulse on the first ready cycle, BVALID the cycle after, data stable throughout.
- BREADY held low for 4 cycles → BVALID held, AWREADY/WREADY low, no second commit; strb = 0 write → no pulse, OKAY.
- Reset asserted in COMMIT and in RESP → BVALID 0 and no pulse the next cycle; subsequent write completes normally; counters preset near max saturate correctly.

Source files
------------

// File: rtl/s_axi_write_mux.sv
// AXI4-Lite write slave for the DFX sequencer register file.
// Accepts AW and W independently, decodes bank0 registers and bank1
// slot-table fields, commits one write at a time against a bank-side
// ready, and keeps saturating OKAY/SLVERR counters.
module s_axi_write_mux #(
   parameter int ADDR_WIDTH        = 16,
   parameter int DATA_WIDTH        = 32,
   parameter int BANK1_INDEX_WIDTH = 2,
   parameter int BANK1_FIELD_COUNT = 6,
   parameter int BANK0_REG_COUNT   = 4,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic                         S_AXI_AWVALID,
   output logic                         S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                         S_AXI_WVALID,
   output logic                         S_AXI_WREADY,
   output logic [1:0]                   S_AXI_BRESP,
   output logic                         S_AXI_BVALID,
   input  logic                         S_AXI_BREADY,
   input  logic                         ext_wr_ready,
   output logic [BANK1_INDEX_WIDTH-1:0] ext_wr_index,
   output logic [DATA_WIDTH-1:0]        ext_wr_data,
   output logic [DATA_WIDTH/8-1:0]      ext_wr_strb,
   output logic [BANK1_FIELD_COUNT-1:0] ext_bank1_set,
   output logic [BANK0_REG_COUNT-1:0]   ext_bank0_set,
   output logic [CNT_WIDTH-1:0]         wr_ok_cnt,
   output logic [CNT_WIDTH-1:0]         wr_err_cnt
);

   localparam int LW = ADDR_WIDTH - 2;

   typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_RESP} state_t;

   state_t                         r_state;
   logic                           r_aw_held, r_w_held;
   logic                           r_awready, r_wready, r_bvalid;
   logic [1:0]                     r_bresp;
   logic                           r_mapped, r_bank1;
   logic [BANK0_REG_COUNT-1:0]     r_b0_oh;
   logic [BANK1_FIELD_COUNT-1:0]   r_b1_oh;
   logic [BANK1_INDEX_WIDTH-1:0]   r_index;
   logic [DATA_WIDTH-1:0]          r_data;
   logic [DATA_WIDTH/8-1:0]        r_strb;
   logic [CNT_WIDTH-1:0]           r_ok_cnt, r_err_cnt;

   logic [1:0]                     w_bank;
   logic [LW-1:0]                  w_addr_low, w_reg_num, w_b1_upper;
   logic [3:0]                     w_field;
   logic                           w_b0_map, w_b1_map;
   logic [BANK0_REG_COUNT-1:0]     w_b0_oh;
   logic [BANK1_FIELD_COUNT-1:0]   w_b1_oh;
   logic                           w_aw_hs, w_w_hs, w_aw_next, w_w_next;
   logic                           w_set_en;

   // Address decode of the incoming AWADDR; registered on AW acceptance
   always_comb begin
      w_bank     = S_AXI_AWADDR[ADDR_WIDTH-1 -: 2];
      w_addr_low = S_AXI_AWADDR[LW-1:0];
      w_reg_num  = w_addr_low >> 6;
      w_b1_upper = w_addr_low >> (6 + BANK1_INDEX_WIDTH);
      w_field    = S_AXI_AWADDR[5:2];
      w_b0_map   = (w_bank == 2'b00) && (w_reg_num < LW'(BANK0_REG_COUNT))
                   && (S_AXI_AWADDR[5:0] == 6'd0);
      w_b1_map   = (w_bank == 2'b01) && ({1'b0, w_field} < 5'(BANK1_FIELD_COUNT))
                   && (w_b1_upper == '0) && (S_AXI_AWADDR[1:0] == 2'b00);
      w_b0_oh    = '0;
      for (int unsigned i = 0; i < BANK0_REG_COUNT; i++)
         w_b0_oh[i] = (w_reg_num == LW'(i));
      w_b1_oh    = '0;
      for (int unsigned i = 0; i < BANK1_FIELD_COUNT; i++)
         w_b1_oh[i] = ({1'b0, w_field} == 5'(i));
   end

   assign w_aw_hs   = S_AXI_AWVALID && r_awready;
   assign w_w_hs    = S_AXI_WVALID && r_wready;
   assign w_aw_next = r_aw_held || w_aw_hs;
   assign w_w_next  = r_w_held || w_w_hs;

   // Set pulses are masked during reset so an abandoned commit never writes
   assign w_set_en = !reset && (r_state == ST_COMMIT) && ext_wr_ready
                     && r_mapped && (r_strb != '0);

   // Channel collection, commit and response sequencing with counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         r_mapped  <= 1'b0;
         r_bank1   <= 1'b0;
         r_b0_oh   <= '0;
         r_b1_oh   <= '0;
         r_index   <= '0;
         r_data    <= '0;
         r_strb    <= '0;
         r_ok_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_aw_hs) begin
                  r_mapped <= w_b0_map || w_b1_map;
                  r_bank1  <= w_b1_map;
                  r_b0_oh  <= w_b0_map ? w_b0_oh : '0;
                  r_b1_oh  <= w_b1_map ? w_b1_oh : '0;
                  r_index  <= S_AXI_AWADDR[6 +: BANK1_INDEX_WIDTH];
               end
               if (w_w_hs) begin
                  r_data <= S_AXI_WDATA;
                  r_strb <= S_AXI_WSTRB;
               end
               r_aw_held <= w_aw_next;
               r_w_held  <= w_w_next;
               if (w_aw_next && w_w_next) begin
                  r_state   <= ST_COMMIT;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
               end else begin
                  r_awready <= !w_aw_next;
                  r_wready  <= !w_w_next;
               end
            end
            ST_COMMIT: begin
               if (!r_mapped) begin
                  r_bresp  <= 2'b10;
                  r_bvalid <= 1'b1;
                  r_state  <= ST_RESP;
                  if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
               end else if (ext_wr_ready) begin
                  r_bresp  <= 2'b00;
                  r_bvalid <= 1'b1;
                  r_state  <= ST_RESP;
                  if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + CNT_WIDTH'(1);
               end
            end
            ST_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign ext_wr_index  = r_index;
   assign ext_wr_data   = r_data;
   assign ext_wr_strb   = r_strb;
   assign ext_bank0_set = (w_set_en && !r_bank1) ? r_b0_oh : '0;
   assign ext_bank1_set = (w_set_en && r_bank1) ? r_b1_oh : '0;
   assign wr_ok_cnt     = r_ok_cnt;
   assign wr_err_cnt    = r_err_cnt;

endmodule
